// File: rtl/l1i_pkg.sv
// Shared types and width helpers for the set-associative L1 instruction cache.
package l1i_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MREQ  = 2'd1,
    MWAIT = 2'd2,
    RESP  = 2'd3
  } l1i_state_e;

  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int set_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int way_w(input int ways);
    return $clog2(ways);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets, input int words);
    return addr_w - $clog2(sets) - $clog2(words);
  endfunction

  // Line entry at the default geometry (14-bit addr, 4 sets, 4 words of 32 bits);
  // the cache declares its own copy sized from its parameters.
  typedef struct packed {
    logic         valid;
    logic [9:0]   tag;
    logic [127:0] data;
  } l1i_line_t;

endpackage

// File: rtl/l1_icache_sa_if.sv
// Fetch-side and memory-side handshake bundle of the L1 instruction cache.
interface l1_icache_sa_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int WORDS  = 4
);
  localparam int LINE_AW = ADDR_W - $clog2(WORDS);

  logic                    req_valid;
  logic [ADDR_W-1:0]       req_addr;
  logic                    req_ready;
  logic                    rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic                    miss;
  logic                    flush;
  logic                    mem_req_valid;
  logic [LINE_AW-1:0]      mem_req_addr;
  logic                    mem_req_ready;
  logic                    mem_rsp_valid;
  logic [WORDS*DATA_W-1:0] mem_rsp_data;

  // slave: the cache itself; master: fetch stage plus memory arbiter
  modport slave (
    input  req_valid, req_addr, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output req_ready, rsp_valid, rsp_data, miss, mem_req_valid, mem_req_addr
  );

  modport master (
    output req_valid, req_addr, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  req_ready, rsp_valid, rsp_data, miss, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/l1i_lru_set.sv
// True-LRU age vector for one cache set; victim is the way whose age is WAYS-1.
module l1i_lru_set import l1i_pkg::*; #(
  parameter int WAYS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   init,
  input  logic                   touch_en,
  input  logic [way_w(WAYS)-1:0] touch_way,
  output logic [way_w(WAYS)-1:0] victim
);
  localparam int WAY_W = way_w(WAYS);

  logic [WAY_W-1:0] age_q [WAYS];
  logic [WAY_W-1:0] age_d [WAYS];
  logic [WAY_W-1:0] touch_age;

  always_comb begin
    age_d     = age_q;
    touch_age = age_q[touch_way];
    victim    = '0;
    if (init) begin
      for (int w = 0; w < WAYS; w++) age_d[w] = WAY_W'(w);
    end else if (touch_en) begin
      // younger ways age by one, the touched way becomes most recent
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == touch_way)     age_d[w] = '0;
        else if (age_q[w] < touch_age)  age_d[w] = age_q[w] + 1'b1;
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (age_q[w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < WAYS; w++) age_q[w] <= WAY_W'(w);
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/l1_icache_sa.sv
// Set-associative L1 I-cache with true-LRU replacement and single-beat line refill.
// Optional hit/miss counters are enabled with the L1I_STATS_EN macro.
//
// state | meaning
// IDLE  | accepting requests, hits answered next cycle, flush handled here
// MREQ  | line request presented to memory until mem_req_ready
// MWAIT | waiting for the refill beat
// RESP  | refilled word being returned
module l1_icache_sa import l1i_pkg::*; #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int SETS   = 4,
  parameter int WAYS   = 4,
  parameter int WORDS  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  l1_icache_sa_if.slave bus
`ifdef L1I_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int OFF_W  = off_w(WORDS);
  localparam int SET_W  = set_w(SETS);
  localparam int WAY_W  = way_w(WAYS);
  localparam int TAG_W  = tag_w(ADDR_W, SETS, WORDS);
  localparam int LINE_W = WORDS * DATA_W;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } line_t;

  l1i_state_e              state_q, state_d;
  line_t                   lines_q [SETS][WAYS];
  line_t                   lines_d [SETS][WAYS];
  logic [TAG_W-1:0]        lat_tag_q, lat_tag_d;
  logic [SET_W-1:0]        lat_set_q, lat_set_d;
  logic [OFF_W-1:0]        lat_word_q, lat_word_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]       rsp_data_q, rsp_data_d;
  logic                    miss_q, miss_d;
  logic                    mem_req_valid_q, mem_req_valid_d;
  logic [TAG_W+SET_W-1:0]  mem_req_addr_q, mem_req_addr_d;

  logic [TAG_W-1:0]  req_tag;
  logic [SET_W-1:0]  req_set;
  logic [OFF_W-1:0]  req_word;
  logic [WAYS-1:0]   hit_vec;
  logic [WAY_W-1:0]  hit_way;
  logic              hit;
  logic [LINE_W-1:0] hit_line;
  logic [WAY_W-1:0]  victim_way;
  logic [WAY_W-1:0]  lru_victim [SETS];
  logic              lru_init, lru_touch;
  logic [SET_W-1:0]  touch_set;
  logic [WAY_W-1:0]  touch_way;
  logic              req_ready;
  logic              accept;

  assign req_tag   = bus.req_addr[ADDR_W-1 -: TAG_W];
  assign req_set   = bus.req_addr[OFF_W +: SET_W];
  assign req_word  = bus.req_addr[OFF_W-1:0];
  assign req_ready = (state_q == IDLE) && !bus.flush;
  assign accept    = bus.req_valid && req_ready;

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (lines_q[req_set][w].valid && (lines_q[req_set][w].tag == req_tag)) begin
        hit_vec[w] = 1'b1;
        hit_way    = WAY_W'(w);
      end
    end
  end

  assign hit      = |hit_vec;
  assign hit_line = lines_q[req_set][hit_way].data;

  // lowest-index invalid way wins over the LRU choice
  always_comb begin
    victim_way = lru_victim[lat_set_q];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!lines_q[lat_set_q][w].valid) victim_way = WAY_W'(w);
    end
  end

  for (genvar s = 0; s < SETS; s++) begin : g_lru
    l1i_lru_set #(.WAYS(WAYS)) u_lru (
      .clk       (clk),
      .rst_n     (rst_n),
      .init      (lru_init),
      .touch_en  (lru_touch && (touch_set == SET_W'(s))),
      .touch_way (touch_way),
      .victim    (lru_victim[s])
    );
  end

  always_comb begin
    state_d         = state_q;
    lines_d         = lines_q;
    lat_tag_d       = lat_tag_q;
    lat_set_d       = lat_set_q;
    lat_word_d      = lat_word_q;
    rsp_valid_d     = 1'b0;
    rsp_data_d      = rsp_data_q;
    miss_d          = miss_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_addr_d  = mem_req_addr_q;
    lru_init        = 1'b0;
    lru_touch       = 1'b0;
    touch_set       = req_set;
    touch_way       = hit_way;
    unique case (state_q)
      IDLE: begin
        if (bus.flush) begin
          for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) lines_d[s][w].valid = 1'b0;
          lru_init = 1'b1;
        end else if (bus.req_valid) begin
          if (hit) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = hit_line[req_word*DATA_W +: DATA_W];
            lru_touch   = 1'b1;
          end else begin
            lat_tag_d       = req_tag;
            lat_set_d       = req_set;
            lat_word_d      = req_word;
            miss_d          = 1'b1;
            mem_req_valid_d = 1'b1;
            mem_req_addr_d  = {req_tag, req_set};
            state_d         = MREQ;
          end
        end
      end
      MREQ: begin
        if (bus.mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = MWAIT;
        end
      end
      MWAIT: begin
        if (bus.mem_rsp_valid) begin
          lines_d[lat_set_q][victim_way].valid = 1'b1;
          lines_d[lat_set_q][victim_way].tag   = lat_tag_q;
          lines_d[lat_set_q][victim_way].data  = bus.mem_rsp_data;
          lru_touch   = 1'b1;
          touch_set   = lat_set_q;
          touch_way   = victim_way;
          rsp_valid_d = 1'b1;
          rsp_data_d  = bus.mem_rsp_data[lat_word_q*DATA_W +: DATA_W];
          miss_d      = 1'b0;
          state_d     = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      lat_tag_q       <= '0;
      lat_set_q       <= '0;
      lat_word_q      <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
      miss_q          <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) lines_q[s][w] <= '0;
    end else begin
      state_q         <= state_d;
      lat_tag_q       <= lat_tag_d;
      lat_set_q       <= lat_set_d;
      lat_word_q      <= lat_word_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      miss_q          <= miss_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
      lines_q         <= lines_d;
    end
  end

  assign bus.req_ready     = req_ready;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.miss          = miss_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_addr  = mem_req_addr_q;

`ifdef L1I_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (accept && hit && (hit_cnt_q != '1))    hit_cnt_d  = hit_cnt_q + 1'b1;
    if (accept && !hit && (miss_cnt_q != '1))  miss_cnt_d = miss_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

  a_single_hit: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(hit_vec));

endmodule

// File: tb/tb_l1_icache_sa.sv
// Directed scoreboard bench for l1_icache_sa; response words are checked as they emerge.
module tb_l1_icache_sa;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] sb [$];
  logic [31:0] mon_exp;
  logic [13:0] ha [4];
  logic [31:0] hw [4];
  logic [127:0] cold_line;

  always #5 clk = ~clk;

  l1_icache_sa_if #(.ADDR_W(14), .DATA_W(32), .WORDS(4)) bif ();

`ifdef L1I_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  l1_icache_sa #(.ADDR_W(14), .DATA_W(32), .SETS(4), .WAYS(4), .WORDS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
`ifdef L1I_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  function automatic logic [31:0] mk_word(input logic [11:0] la, input int k);
    return {8'hA5, la, 12'(k)};
  endfunction

  function automatic logic [127:0] mk_line(input logic [11:0] la);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = mk_word(la, k);
    return l;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // every rsp_valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bif.rsp_valid === 1'b1) begin
      mon_exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
      total++;
      assert (bif.rsp_data === mon_exp) else begin
        bad++;
        $error("FAIL rsp_data observed=%0h expected=%0h", bif.rsp_data, mon_exp);
      end
    end
  end

  // Starts and ends one time unit after a rising edge.
  task automatic do_miss(input logic [13:0] addr, input logic [127:0] line, input int stall);
    bif.req_valid = 1'b1;
    bif.req_addr  = addr;
    @(negedge clk);
    chk("miss_req_ready", bif.req_ready, 1);
    sb.push_back(line[addr[1:0]*32 +: 32]);
    @(posedge clk); #1;
    bif.req_valid = 1'b0;
    @(negedge clk);
    chk("miss_flag", bif.miss, 1);
    chk("mreq_valid", bif.mem_req_valid, 1);
    chk("mreq_addr", bif.mem_req_addr, addr[13:2]);
    chk("miss_req_ready_low", bif.req_ready, 0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_mreq_valid", bif.mem_req_valid, 1);
      chk("stall_mreq_addr", bif.mem_req_addr, addr[13:2]);
      chk("stall_miss", bif.miss, 1);
      chk("stall_no_rsp", bif.rsp_valid, 0);
    end
    bif.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bif.mem_req_ready = 1'b0;
    @(negedge clk);
    chk("mwait_mreq_low", bif.mem_req_valid, 0);
    chk("mwait_miss", bif.miss, 1);
    bif.mem_rsp_valid = 1'b1;
    bif.mem_rsp_data  = line;
    @(posedge clk); #1;
    bif.mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("refill_rsp_valid", bif.rsp_valid, 1);
    chk("refill_miss_clear", bif.miss, 0);
    @(posedge clk); #1;
  endtask

  // Back-to-back hits over ha[0..n-1] expecting hw[0..n-1].
  task automatic hit_burst(input int n);
    for (int i = 0; i < n; i++) begin
      bif.req_valid = 1'b1;
      bif.req_addr  = ha[i];
      @(negedge clk);
      chk("hit_req_ready", bif.req_ready, 1);
      chk("hit_no_mreq", bif.mem_req_valid, 0);
      if (i > 0) chk("hit_b2b_rsp", bif.rsp_valid, 1);
      sb.push_back(hw[i]);
      @(posedge clk); #1;
    end
    bif.req_valid = 1'b0;
    @(negedge clk);
    chk("hit_rsp_next_cycle", bif.rsp_valid, 1);
    chk("hit_no_miss", bif.miss, 0);
    chk("hit_no_mreq_after", bif.mem_req_valid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n             = 1'b0;
    bif.req_valid     = 1'b0;
    bif.req_addr      = '0;
    bif.flush         = 1'b0;
    bif.mem_req_ready = 1'b0;
    bif.mem_rsp_valid = 1'b0;
    bif.mem_rsp_data  = '0;
    cold_line         = {32'h44, 32'h33, 32'h22, 32'h11};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bif.req_ready, 1);
    chk("rst_rsp_valid", bif.rsp_valid, 0);
    chk("rst_rsp_data", bif.rsp_data, 0);
    chk("rst_miss", bif.miss, 0);
    chk("rst_mreq_valid", bif.mem_req_valid, 0);
    chk("rst_mreq_addr", bif.mem_req_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // cold miss then hits in the same line
    do_miss(14'h0005, cold_line, 0);
    ha = '{14'h0005, 14'h0004, 14'h0007, 14'h0006};
    hw = '{32'h22, 32'h11, 32'h44, 32'h33};
    hit_burst(4);

    // fill set 0, touch tag 0, tag 4 must evict tag 1
    do_miss(14'h000, mk_line(12'h000), 0);
    do_miss(14'h010, mk_line(12'h004), 0);
    do_miss(14'h021, mk_line(12'h008), 0);
    do_miss(14'h033, mk_line(12'h00C), 0);
    ha[0] = 14'h000; hw[0] = mk_word(12'h000, 0);
    hit_burst(1);
    do_miss(14'h040, mk_line(12'h010), 0);
    ha = '{14'h000, 14'h022, 14'h031, 14'h043};
    hw = '{mk_word(12'h000, 0), mk_word(12'h008, 2), mk_word(12'h00C, 1), mk_word(12'h010, 3)};
    hit_burst(4);
    do_miss(14'h012, mk_line(12'h004), 0);

    // memory holds off the request for five cycles
    do_miss(14'h101, mk_line(12'h040), 5);

    // flush and request in the same cycle
    ha[0] = 14'h0005; hw[0] = 32'h22;
    hit_burst(1);
    bif.flush     = 1'b1;
    bif.req_valid = 1'b1;
    bif.req_addr  = 14'h0005;
    @(negedge clk);
    chk("flush_req_ready_low", bif.req_ready, 0);
    @(posedge clk); #1;
    bif.flush     = 1'b0;
    bif.req_valid = 1'b0;
    @(negedge clk);
    chk("flush_no_rsp", bif.rsp_valid, 0);
    chk("flush_no_mreq", bif.mem_req_valid, 0);
    @(posedge clk); #1;
    do_miss(14'h0005, cold_line, 0);

    // reset while waiting for the refill; the late beat must be ignored
    bif.req_valid = 1'b1;
    bif.req_addr  = 14'h0008;
    @(posedge clk); #1;
    bif.req_valid     = 1'b0;
    bif.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bif.mem_req_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_miss", bif.miss, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_miss", bif.miss, 0);
    chk("rst_mid_mreq_valid", bif.mem_req_valid, 0);
    chk("rst_mid_req_ready", bif.req_ready, 1);
    @(posedge clk); #1;
    rst_n             = 1'b1;
    bif.mem_rsp_valid = 1'b1;
    bif.mem_rsp_data  = mk_line(12'h002);
    @(posedge clk); #1;
    bif.mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("late_rsp_ignored", bif.rsp_valid, 0);
    chk("late_rsp_no_miss", bif.miss, 0);
    @(posedge clk); #1;
    do_miss(14'h0005, cold_line, 0);

`ifdef L1I_STATS_EN
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_miss(14'h0005, cold_line, 0);
    do_miss(14'h0011, mk_line(12'h004), 0);
    ha = '{14'h0005, 14'h0004, 14'h0011, 14'h0000};
    hw = '{32'h22, 32'h11, mk_word(12'h004, 1), 32'h0};
    hit_burst(3);
    chk("stats_hit_cnt", hit_cnt, 3);
    chk("stats_miss_cnt", miss_cnt, 2);
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
